// File: rtl/arb_adder4bit00_pkg.sv
// Shared types and constants for the two-requester arbitrated adder/subtractor.
package arb_adder4bit00_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/arb_adder4bit00_adder.sv
// Combinational add/subtract unit shared by both requesters.
module adder4bit
  import arb_adder4bit00_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  logic [WIDTH-1:0] b_eff_s;
  logic             cin_s;
  logic [WIDTH:0]   sum_s;

  // Subtract is A + ~B + 1, so C reads as "no borrow".
  always_comb begin
    if (op == OP_SUB) begin
      b_eff_s = ~B;
      cin_s   = 1'b1;
    end else begin
      b_eff_s = B;
      cin_s   = 1'b0;
    end
    sum_s = {1'b0, A} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
    S     = sum_s[WIDTH-1:0];
    C     = sum_s[WIDTH];
    V     = (A[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
  end

endmodule

// File: rtl/arb_adder4bit00.sv
// Round-robin arbiter sharing one adder/subtractor between two requesters
// through an IDLE -> CALC -> ACK handshake.
module arb_adder4bit00
  import arb_adder4bit00_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk0,
  input  logic             reset0,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic             op0,
  input  logic             op1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] R0,
  output logic [WIDTH-1:0] R1,
  output logic             C0,
  output logic             C1,
  output logic             V0,
  output logic             V1,
  output logic [WIDTH-1:0] LED,
  output logic             busy
);

  state_t           state_r, state_nxt_s;
  logic             last_r;
  logic             latch_s, done_s, grant_s;
  logic [WIDTH-1:0] a_r, b_r, a_sel_s, b_sel_s;
  logic             op_r, op_sel_s;
  logic [WIDTH-1:0] sum_s;
  logic             c_s, v_s;

  adder4bit #(.WIDTH(WIDTH)) u_adder (
    .A  (a_r),
    .B  (b_r),
    .op (op_r),
    .S  (sum_s),
    .C  (c_s),
    .V  (v_s)
  );

  // Next-state, grant decision and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    latch_s     = 1'b0;
    done_s      = 1'b0;
    grant_s     = last_r;
    case (state_r)
      ST_IDLE: begin
        if (req0 || req1) begin
          latch_s     = 1'b1;
          state_nxt_s = ST_CALC;
          if (req0 && req1) begin
            grant_s = ~last_r;
          end else begin
            grant_s = req1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        done_s      = 1'b1;
        state_nxt_s = ST_ACK;
      end
      ST_ACK:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand select for the requester being granted.
  always_comb begin
    if (grant_s) begin
      a_sel_s  = A1;
      b_sel_s  = B1;
      op_sel_s = op1;
    end else begin
      a_sel_s  = A0;
      b_sel_s  = B0;
      op_sel_s = op0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk0 or posedge reset0) begin
    if (reset0) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // last_r doubles as the in-flight grant while in CALC/ACK.
  always_ff @(posedge clk0 or posedge reset0) begin
    if (reset0) begin
      last_r <= 1'b1;
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      op_r   <= OP_ADD;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      R0     <= {WIDTH{1'b0}};
      R1     <= {WIDTH{1'b0}};
      C0     <= 1'b0;
      C1     <= 1'b0;
      V0     <= 1'b0;
      V1     <= 1'b0;
      LED    <= {WIDTH{1'b0}};
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (latch_s) begin
        last_r <= grant_s;
        a_r    <= a_sel_s;
        b_r    <= b_sel_s;
        op_r   <= op_sel_s;
      end
      if (done_s) begin
        LED <= sum_s;
        if (last_r) begin
          R1   <= sum_s;
          C1   <= c_s;
          V1   <= v_s;
          ack1 <= 1'b1;
        end else begin
          R0   <= sum_s;
          C0   <= c_s;
          V0   <= v_s;
          ack0 <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_arb_adder4bit00.sv
// Directed plus randomized bench for arb_adder4bit00 against an arithmetic reference model.
module tb_arb_adder4bit00;

  logic       clk0 = 1'b0;
  logic       reset0 = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] A0 = 4'd0, B0 = 4'd0, A1 = 4'd0, B1 = 4'd0;
  logic       op0 = 1'b0, op1 = 1'b0;
  logic       ack0, ack1, C0, C1, V0, V1, busy;
  logic [3:0] R0, R1, LED;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_r[2], exp_c[2], exp_v[2];
  int exp_led, exp_last;

  arb_adder4bit00 #(.WIDTH(4)) dut (
    .clk0(clk0), .reset0(reset0), .req0(req0), .req1(req1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1), .op0(op0), .op1(op1),
    .ack0(ack0), .ack1(ack1), .R0(R0), .R1(R1), .C0(C0), .C1(C1),
    .V0(V0), .V1(V1), .LED(LED), .busy(busy)
  );

  always #5 clk0 = ~clk0;

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_r[i] = 0;
      exp_c[i] = 0;
      exp_v[i] = 0;
    end
    exp_led  = 0;
    exp_last = 1;
  endtask

  // Reference: unsigned sum gives R/C, signed arithmetic range gives V.
  task automatic complete(input int w, input int a, input int b, input int op);
    int u, s, sa, sb;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    if (op == 0) begin
      u = a + b;
      s = sa + sb;
    end else begin
      u = a + 16 - b;
      s = sa - sb;
    end
    exp_r[w] = u % 16;
    exp_c[w] = (u >= 16) ? 1 : 0;
    exp_v[w] = (s > 7 || s < -8) ? 1 : 0;
    exp_led  = u % 16;
    exp_last = w;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_R0"}, 32'(R0), exp_r[0]);
    check({tag, "_C0"}, 32'(C0), exp_c[0]);
    check({tag, "_V0"}, 32'(V0), exp_v[0]);
    check({tag, "_R1"}, 32'(R1), exp_r[1]);
    check({tag, "_C1"}, 32'(C1), exp_c[1]);
    check({tag, "_V1"}, 32'(V1), exp_v[1]);
    check({tag, "_LED"}, 32'(LED), exp_led);
  endtask

  // Called in IDLE with requests set up; runs one operation to completion.
  task automatic serve(input string tag, input bit scramble);
    int w, a, b, op, n;
    if (req0 && req1) w = 1 - exp_last;
    else w = req1 ? 1 : 0;
    a  = (w == 1) ? int'(A1) : int'(A0);
    b  = (w == 1) ? int'(B1) : int'(B0);
    op = (w == 1) ? int'(op1) : int'(op0);
    tick();
    n = 1;
    check({tag, "_busy_calc"}, 32'(busy), 32'd1);
    if (scramble) begin
      if (w == 1) begin
        A1 = 4'($urandom_range(0, 15)); B1 = 4'($urandom_range(0, 15)); op1 = ~op1;
      end else begin
        A0 = 4'($urandom_range(0, 15)); B0 = 4'($urandom_range(0, 15)); op0 = ~op0;
      end
    end
    while (n < 6 && !(ack0 || ack1)) begin
      tick();
      n++;
    end
    check({tag, "_ack_seen"}, 32'(ack0 | ack1), 32'd1);
    check({tag, "_latency"}, n, 2);
    check({tag, "_ack_excl"}, 32'(ack0 & ack1), 32'd0);
    check({tag, "_grant"}, ack1 ? 32'd1 : 32'd0, w);
    complete(w, a, b, op);
    check_outputs(tag);
    if (w == 1) req1 = 1'b0;
    else req0 = 1'b0;
    tick();
    check({tag, "_ack_pulse"}, 32'({ack0, ack1}), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int exp_w, last_ack, nacks, who;
    model_reset();

    // Asynchronous reset, observed before any clock edge.
    #2 reset0 = 1'b1;
    #1;
    check_outputs("reset");
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ack", 32'({ack0, ack1}), 32'd0);
    tick();
    reset0 = 1'b0;

    // Single add.
    A0 = 4'h5; B0 = 4'h3; op0 = 1'b0; req0 = 1'b1;
    serve("add", 1'b0);
    check("add_R0_const", 32'(R0), 32'h8);
    check("add_LED_const", 32'(LED), 32'h8);

    // Carry and overflow.
    A1 = 4'h9; B1 = 4'h9; op1 = 1'b0; req1 = 1'b1;
    serve("ovf", 1'b0);
    check("ovf_R1_const", 32'(R1), 32'h2);
    check("ovf_C1V1_const", 32'({C1, V1}), 32'h3);

    // Tie straight out of reset: requester 0 wins first.
    reset0 = 1'b1;
    model_reset();
    A0 = 4'h3; B0 = 4'h5; op0 = 1'b1; req0 = 1'b1;
    A1 = 4'h7; B1 = 4'h2; op1 = 1'b1; req1 = 1'b1;
    tick();
    reset0 = 1'b0;
    serve("tie0", 1'b0);
    check("tie_R0_const", 32'({R0, C0}), 32'h1C);
    serve("tie1", 1'b0);
    check("tie_R1_const", 32'({R1, C1}), 32'hB);

    // Fairness: both held for 12 cycles.
    A0 = 4'h1; B0 = 4'h2; op0 = 1'b0; req0 = 1'b1;
    A1 = 4'h6; B1 = 4'h3; op1 = 1'b1; req1 = 1'b1;
    exp_w = 1 - exp_last;
    last_ack = 0;
    nacks = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check("fair_ack_excl", 32'(ack0 & ack1), 32'd0);
      if (ack0 || ack1) begin
        who = ack1 ? 1 : 0;
        check("fair_grant", who, exp_w);
        check("fair_gap", t - last_ack, (nacks == 0) ? 2 : 3);
        complete(exp_w, (exp_w == 1) ? int'(A1) : int'(A0), (exp_w == 1) ? int'(B1) : int'(B0),
                 (exp_w == 1) ? int'(op1) : int'(op0));
        check_outputs("fair");
        exp_w = 1 - exp_w;
        last_ack = t;
        nacks++;
      end
    end
    check("fair_count", nacks, 4);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();

    // Randomized traffic; the loser of a tie keeps its request pending.
    for (int it = 0; it < 40; it++) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin
        A0 = 4'($urandom_range(0, 15)); B0 = 4'($urandom_range(0, 15));
        op0 = 1'($urandom_range(0, 1)); req0 = 1'b1;
      end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        A1 = 4'($urandom_range(0, 15)); B1 = 4'($urandom_range(0, 15));
        op1 = 1'($urandom_range(0, 1)); req1 = 1'b1;
      end
      if (!req0 && !req1) begin
        A0 = 4'($urandom_range(0, 15)); B0 = 4'($urandom_range(0, 15));
        op0 = 1'($urandom_range(0, 1)); req0 = 1'b1;
      end
      serve("rand", 1'b1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();

    // Abort in CALC, then a fresh request.
    A0 = 4'hA; B0 = 4'h4; op0 = 1'b0; req0 = 1'b1;
    tick();
    check("abort_in_calc", 32'(busy), 32'd1);
    reset0 = 1'b1;
    req0 = 1'b0;
    model_reset();
    #1;
    check_outputs("abort");
    check("abort_busy", 32'(busy), 32'd0);
    tick();
    check("abort_no_ack", 32'({ack0, ack1}), 32'd0);
    reset0 = 1'b0;
    tick();
    check("abort_still_no_ack", 32'({ack0, ack1}), 32'd0);
    check("abort_R0", 32'(R0), 32'd0);
    A0 = 4'h6; B0 = 4'h7; op0 = 1'b1; req0 = 1'b1;
    serve("after_abort", 1'b0);
    check("after_abort_R0_const", 32'(R0), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
